// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//   Packs decoded RV32I fields into 32-bit instruction words and presents them,
//   tagged with a sequential byte address, on a write port for instruction BRAM.
//   Rejected requests (bad immediate, bad funct3, bad kind) are consumed, pulse
//   err_o and leave the address counter and word count untouched.
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   start_i                     restart addressing at BASE_ADDR, clear word_cnt_o
//   in_valid_i / in_ready_o     input field handshake
//   kind_i, fn3_i, alt_i        instruction kind, funct3, alternate funct7
//   rd_i, rs1_i, rs2_i, imm_i   register indices and signed immediate
//   out_valid_o / out_ready_i   encoded word handshake
//   out_word_o, out_addr_o      encoded instruction and its byte address
//   out_we_o                    byte write enables (all set while a word is pending)
//   err_o, err_code_o           reject pulse and sticky reason (1 imm, 2 fn3, 3 kind)
//   word_cnt_o                  saturating count of emitted words since start_i
module inst_encoder_loader #(
  parameter int unsigned              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]        BASE_ADDR   = '0,
  parameter int unsigned              DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        kind_i,
  input  logic [2:0]        fn3_i,
  input  logic              alt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_word_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [3:0]        out_we_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [15:0]       word_cnt_o
);

  typedef enum logic [3:0] {
    KIND_R     = 4'd0,
    KIND_I     = 4'd1,
    KIND_LOAD  = 4'd2,
    KIND_S     = 4'd3,
    KIND_B     = 4'd4,
    KIND_LUI   = 4'd5,
    KIND_AUIPC = 4'd6,
    KIND_JAL   = 4'd7,
    KIND_JALR  = 4'd8
  } kind_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH_WORDS - 1));

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q,  out_word_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_cnt_q,  addr_cnt_d;
  logic              err_q,       err_d;
  logic [1:0]        err_code_q,  err_code_d;
  logic [15:0]       word_cnt_q,  word_cnt_d;

  logic signed [31:0] imm_s;
  logic [6:0]         funct7;
  logic               imm12_ok, b_ok, j_ok, shamt_ok, u_ok;
  logic [31:0]        enc_word;
  logic [1:0]         enc_code;
  logic               accept, out_hs;
  logic [ADDR_W-1:0]  tag;

  assign imm_s    = imm_i;
  assign funct7   = alt_i ? 7'b0100000 : 7'b0000000;
  assign imm12_ok = (imm_s >= -2048) && (imm_s <= 2047);
  assign b_ok     = (imm_s >= -4096) && (imm_s <= 4094) && !imm_i[0];
  assign j_ok     = (imm_s >= -1048576) && (imm_s <= 1048574) && !imm_i[0];
  assign shamt_ok = (imm_i[31:5] == '0);
  assign u_ok     = (imm_i[11:0] == '0);

  // Encoder. Within each kind the funct3 check is applied after the range
  // check so the higher error code wins when both apply.
  always_comb begin
    enc_word = '0;
    enc_code = 2'd0;
    case (kind_i)
      KIND_R: enc_word = {funct7, rs2_i, rs1_i, fn3_i, rd_i, OP_R};
      KIND_I: begin
        if (fn3_i == 3'b001 || fn3_i == 3'b101) begin
          enc_word = {funct7, imm_i[4:0], rs1_i, fn3_i, rd_i, OP_I};
          if (!shamt_ok) enc_code = 2'd1;
        end else begin
          enc_word = {imm_i[11:0], rs1_i, fn3_i, rd_i, OP_I};
          if (!imm12_ok) enc_code = 2'd1;
          if (fn3_i == 3'b000 && alt_i) enc_code = 2'd2;
        end
      end
      KIND_LOAD: begin
        enc_word = {imm_i[11:0], rs1_i, fn3_i, rd_i, OP_LOAD};
        if (!imm12_ok) enc_code = 2'd1;
        if (fn3_i == 3'b011 || fn3_i == 3'b110 || fn3_i == 3'b111) enc_code = 2'd2;
      end
      KIND_S: begin
        enc_word = {imm_i[11:5], rs2_i, rs1_i, fn3_i, imm_i[4:0], OP_S};
        if (!imm12_ok) enc_code = 2'd1;
        if (fn3_i >= 3'b011) enc_code = 2'd2;
      end
      KIND_B: begin
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, fn3_i, imm_i[4:1], imm_i[11], OP_B};
        if (!b_ok) enc_code = 2'd1;
        if (fn3_i == 3'b010 || fn3_i == 3'b011) enc_code = 2'd2;
      end
      KIND_LUI: begin
        enc_word = {imm_i[31:12], rd_i, OP_LUI};
        if (!u_ok) enc_code = 2'd1;
      end
      KIND_AUIPC: begin
        enc_word = {imm_i[31:12], rd_i, OP_AUIPC};
        if (!u_ok) enc_code = 2'd1;
      end
      KIND_JAL: begin
        enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        if (!j_ok) enc_code = 2'd1;
      end
      KIND_JALR: begin
        enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
        if (!imm12_ok) enc_code = 2'd1;
      end
      default: enc_code = 2'd3;
    endcase
  end

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign out_hs     = out_valid_q && out_ready_i;
  // start_i overrides the counter for a word accepted in the same cycle.
  assign tag        = start_i ? BASE_ADDR : addr_cnt_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    addr_cnt_d  = start_i ? BASE_ADDR : addr_cnt_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    word_cnt_d  = word_cnt_q;

    if (out_hs) out_valid_d = 1'b0;

    if (accept) begin
      if (enc_code != 2'd0) begin
        err_d      = 1'b1;
        err_code_d = enc_code;
      end else begin
        out_valid_d = 1'b1;
        out_word_d  = enc_word;
        out_addr_d  = tag;
        addr_cnt_d  = (tag == LAST_ADDR) ? BASE_ADDR : tag + ADDR_W'(4);
      end
    end

    if (start_i)
      word_cnt_d = out_hs ? 16'd1 : '0;
    else if (out_hs && word_cnt_q != '1)
      word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= BASE_ADDR;
      addr_cnt_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      addr_cnt_q  <= addr_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign out_addr_o  = out_addr_q;
  assign out_we_o    = out_valid_q ? 4'b1111 : 4'b0000;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
